img_writeback_buffer: RTL and testbench



---
 rtl/img_writeback_buffer.sv | 138 +++++++++++++
 tb/tb_img_writeback_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_writeback_buffer.sv
// img_writeback_buffer: buffers the accumulated pixel stream and re-emits it as fixed-length write bursts
module img_writeback_buffer #(
    parameter int IMG_N        = 258,
    parameter int FIFO_DEPTH   = 64,
    parameter int BURST_LEN    = 16,
    parameter int AFULL_MARGIN = 16
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        start_wb,
    input  logic [31:0]                 in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [31:0]                 m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        m_tlast,
    output logic                        m_tuser,
    output logic                        wb_done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fill_level
);
    localparam int TOTAL_NUM = IMG_N * IMG_N;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int PW        = $clog2(TOTAL_NUM + 1);
    localparam int LW        = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {S_FILL, S_BURST, S_DONE} state_t;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic [PW-1:0] r_pix;
    logic [LW-1:0] r_beat;
    logic [LW-1:0] r_len;
    logic          r_fend;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_next_last;
    logic [PW-1:0] w_rem;
    logic [LW-1:0] w_len;

    assign w_full      = r_count == CW'(FIFO_DEPTH);
    assign w_push      = in_valid && !w_full && !start_wb;
    assign w_pop       = m_tvalid && m_tready && !start_wb;
    assign w_rem       = PW'(TOTAL_NUM) - r_pix;
    assign w_len       = (w_rem < PW'(BURST_LEN)) ? w_rem[LW-1:0] : LW'(BURST_LEN);
    assign w_next_last = (r_beat + LW'(2)) == r_len;
    assign in_ready    = r_count < CW'(FIFO_DEPTH - AFULL_MARGIN);
    assign fill_level  = r_count;

    // storage array; contents are only read where the occupancy count guarantees a valid entry
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in_data;
    end

    // pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else if (start_wb) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            r_wptr   <= w_push ? r_wptr + AW'(1) : r_wptr;
            r_rptr   <= w_pop ? r_rptr + AW'(1) : r_rptr;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            overflow <= overflow || (in_valid && w_full);
        end
    end

    // burst sequencer: waits for a whole burst in the buffer, then streams it with registered outputs
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state  <= S_FILL;
            r_pix    <= '0;
            r_beat   <= '0;
            r_len    <= '0;
            r_fend   <= 1'b0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            wb_done  <= 1'b0;
        end else if (start_wb) begin
            r_state  <= S_FILL;
            r_pix    <= '0;
            r_beat   <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            wb_done  <= 1'b0;
        end else begin
            wb_done <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (fill_level >= CW'(w_len)) begin
                        r_state  <= S_BURST;
                        r_len    <= w_len;
                        r_fend   <= (w_rem <= PW'(BURST_LEN));
                        r_beat   <= '0;
                        m_tdata  <= r_mem[r_rptr];
                        m_tvalid <= 1'b1;
                        m_tlast  <= w_len == LW'(1);
                        m_tuser  <= w_rem == PW'(1);
                    end
                end
                S_BURST: begin
                    if (w_pop && m_tlast) begin
                        r_state  <= r_fend ? S_DONE : S_FILL;
                        r_pix    <= r_fend ? '0 : r_pix + PW'(1);
                        r_beat   <= '0;
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        m_tuser  <= 1'b0;
                        wb_done  <= r_fend;
                    end else if (w_pop) begin
                        r_pix   <= r_pix + PW'(1);
                        r_beat  <= r_beat + LW'(1);
                        m_tdata <= r_mem[r_rptr + AW'(1)];
                        m_tlast <= w_next_last;
                        m_tuser <= r_fend && w_next_last;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_img_writeback_buffer.sv
// tb_img_writeback_buffer: randomized scenario checks of the writeback burst buffer against a stream-level model
module tb_img_writeback_buffer;
    localparam int IMG_N  = 18;
    localparam int DEPTH  = 64;
    localparam int BL     = 16;
    localparam int MARGIN = 16;
    localparam int TOTAL  = IMG_N * IMG_N;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          start_wb = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          m_tready = 1'b0;
    logic          in_ready;
    logic [31:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tuser;
    logic          wb_done;
    logic          overflow;
    logic [CW-1:0] fill_level;

    int tests = 0;
    int fails = 0;

    logic [31:0] obs_data[$];
    bit          obs_last[$];
    bit          obs_user[$];
    int          done_cnt = 0;
    int          max_fill = 0;
    int          ready_bad = 0;
    int          hold_bad = 0;
    int          drop_bad = 0;
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_last = 1'b0;
    logic        p_start = 1'b0;
    logic [31:0] p_data = '0;

    img_writeback_buffer #(
        .IMG_N(IMG_N), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .AFULL_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .arstn(arstn), .start_wb(start_wb), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .wb_done(wb_done), .overflow(overflow),
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    // record accepted beats and protocol observations at the inactive edge
    always @(negedge clk) begin
        if (arstn) begin
            if (m_tvalid && m_tready) begin
                obs_data.push_back(m_tdata);
                obs_last.push_back(m_tlast);
                obs_user.push_back(m_tuser);
            end
            if (wb_done) done_cnt++;
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            if (in_ready !== (int'(fill_level) < DEPTH - MARGIN)) ready_bad++;
            if (p_valid && !p_start && !p_ready && (!m_tvalid || m_tdata !== p_data)) hold_bad++;
            if (p_valid && !p_start && !(p_ready && p_last) && !m_tvalid) drop_bad++;
            if (p_valid && p_ready && p_last && m_tvalid) drop_bad++;
        end
        p_valid = m_tvalid;
        p_ready = m_tready;
        p_last  = m_tlast;
        p_start = start_wb;
        p_data  = m_tdata;
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start_wb = 1'b1;
        in_valid = 1'b0;
        m_tready = 1'b0;
        @(posedge clk); #1;
        start_wb = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset m_tvalid: got %b expected 0", m_tvalid); end
        tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL reset m_tlast: got %b expected 0", m_tlast); end
        tests++; if (m_tuser !== 1'b0) begin fails++; $display("FAIL reset m_tuser: got %b expected 0", m_tuser); end
        tests++; if (m_tdata !== 32'd0) begin fails++; $display("FAIL reset m_tdata: got %0d expected 0", m_tdata); end
        tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL reset wb_done: got %b expected 0", wb_done); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset overflow: got %b expected 0", overflow); end
        tests++; if (fill_level !== '0) begin fails++; $display("FAIL reset fill_level: got %0d expected 0", fill_level); end
        arstn = 1'b1;
        @(posedge clk); #1;
    endtask

    // pushes nfr whole frames of data base+i while honouring in_ready; expected stream follows frame/burst rules
    task automatic test_frame(input string name, input int nfr, input int ready_pct, input int gap_pct, input int base);
        int o0 = obs_data.size();
        int d0 = done_cnt;
        int rb0 = ready_bad;
        int hb0 = hold_bad;
        int db0 = drop_bad;
        int total = nfr * TOTAL;
        int limit = total * 10 + 500;
        int sent = 0;
        int cyc = 0;
        int n;
        while ((sent < total || done_cnt - d0 < nfr) && cyc < limit) begin
            @(posedge clk); #1;
            m_tready = $urandom_range(99) < ready_pct;
            if (sent < total && in_ready && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = 32'(base + sent);
                sent++;
            end else in_valid = 1'b0;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (cyc >= limit) begin fails++; $display("FAIL %s timeout: got %0d cycles required under %0d", name, cyc, limit); end
        n = obs_data.size() - o0;
        tests++; if (n != total) begin fails++; $display("FAIL %s beat count: got %0d expected %0d", name, n, total); end
        for (int i = 0; i < n && i < total; i++) begin
            int k = i % TOTAL;
            bit el = ((k + 1) % BL == 0) || (k == TOTAL - 1);
            bit eu = k == TOTAL - 1;
            tests++;
            if (obs_data[o0+i] !== 32'(base + i) || obs_last[o0+i] !== el || obs_user[o0+i] !== eu) begin
                fails++;
                $display("FAIL %s beat %0d: got data=%0d last=%b user=%b expected data=%0d last=%b user=%b",
                         name, i, obs_data[o0+i], obs_last[o0+i], obs_user[o0+i], base + i, el, eu);
                break;
            end
        end
        tests++; if (done_cnt - d0 != nfr) begin fails++; $display("FAIL %s wb_done pulses: got %0d expected %0d", name, done_cnt - d0, nfr); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL %s overflow: got %b expected 0", name, overflow); end
        tests++; if (max_fill > DEPTH) begin fails++; $display("FAIL %s max fill_level: got %0d expected <= %0d", name, max_fill, DEPTH); end
        tests++; if (ready_bad != rb0) begin fails++; $display("FAIL %s in_ready vs fill_level: got %0d bad cycles expected 0", name, ready_bad - rb0); end
        tests++; if (hold_bad != hb0) begin fails++; $display("FAIL %s m_tdata hold: got %0d bad cycles expected 0", name, hold_bad - hb0); end
        tests++; if (drop_bad != db0) begin fails++; $display("FAIL %s m_tvalid framing: got %0d bad cycles expected 0", name, drop_bad - db0); end
    endtask

    task automatic test_overflow();
        int o0;
        int n;
        pulse_start();
        o0 = obs_data.size();
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 32'(9000 + i);
            m_tready = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (fill_level !== CW'(DEPTH)) begin fails++; $display("FAIL overflow fill_level: got %0d expected %0d", fill_level, DEPTH); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow flag: got %b expected 1", overflow); end
        tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL overflow stalled m_tvalid: got %b expected 1", m_tvalid); end
        m_tready = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        n = obs_data.size() - o0;
        tests++; if (n != DEPTH) begin fails++; $display("FAIL overflow drained count: got %0d expected %0d", n, DEPTH); end
        for (int i = 0; i < n && i < DEPTH; i++) begin
            tests++;
            if (obs_data[o0+i] !== 32'(9000 + i)) begin
                fails++; $display("FAIL overflow drained beat %0d: got %0d expected %0d", i, obs_data[o0+i], 9000 + i);
                break;
            end
        end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow sticky: got %b expected 1", overflow); end
        pulse_start();
        tests++; if (fill_level !== '0) begin fails++; $display("FAIL overflow flush fill_level: got %0d expected 0", fill_level); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL overflow clear: got %b expected 0", overflow); end
    endtask

    task automatic test_midburst_start();
        int o0;
        int sent = 0;
        bit hit = 0;
        pulse_start();
        o0 = obs_data.size();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (obs_data.size() - o0 >= 7) begin hit = 1; break; end
            m_tready = 1'b1;
            in_valid = sent < 20;
            in_data  = 32'(7000 + sent);
            if (sent < 20) sent++;
        end
        tests++; if (!hit) begin fails++; $display("FAIL midburst timeout: got %0d beats expected 7", obs_data.size() - o0); end
        tests++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd7007) begin fails++; $display("FAIL midburst beat7: got valid=%b data=%0d expected valid=1 data=7007", m_tvalid, m_tdata); end
        start_wb = 1'b1;
        m_tready = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start_wb = 1'b0;
        in_valid = 1'b0;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL midburst m_tvalid after start_wb: got %b expected 0", m_tvalid); end
        tests++; if (fill_level !== '0) begin fails++; $display("FAIL midburst fill_level after start_wb: got %0d expected 0", fill_level); end
        for (int i = 0; i < 7 && o0 + i < obs_data.size(); i++) begin
            tests++;
            if (obs_data[o0+i] !== 32'(7000 + i) || obs_last[o0+i] !== 1'b0) begin
                fails++; $display("FAIL midburst beat %0d: got data=%0d last=%b expected data=%0d last=0", i, obs_data[o0+i], obs_last[o0+i], 7000 + i);
                break;
            end
        end
        repeat (3) @(posedge clk);
        test_frame("restart", 1, 100, 0, 5000);
    endtask

    task automatic test_short_fill();
        pulse_start();
        m_tready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 32'(3000 + i);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL short_fill idle %0d m_tvalid: got %b expected 0", c, m_tvalid); end
        end
        in_valid = 1'b1;
        in_data  = 32'd3015;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL short_fill decision cycle m_tvalid: got %b expected 0", m_tvalid); end
        @(posedge clk); #1;
        tests++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd3000) begin fails++; $display("FAIL short_fill first beat: got valid=%b data=%0d expected valid=1 data=3000", m_tvalid, m_tdata); end
    endtask

    initial begin
        test_reset();
        test_frame("contiguous", 1, 100, 0, 0);
        test_frame("random_ready", 1, 30, 25, 100000);
        test_frame("back_to_back", 2, 100, 0, 200000);
        test_overflow();
        test_midburst_start();
        test_short_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
